tlul_fifo_bridge: RTL

TL-UL device adapter placed directly in front of the synchronous FIFO core, the bus-facing stage that feeds it. Decodes single-beat TL-UL accesses from the crossbar into FIFO push/pop strobes and a status readback. Returns one TL-UL response per request, with one cycle of latency. All bus widths come from the shared TL-UL package constants: TL_AW, TL_DW, TL_AIW, TL_DIW, TL_DBW and TL_SZW.

---
 rtl/tlul_fifo_bridge.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/tlul_fifo_bridge.sv
// TL-UL device adapter for the synchronous FIFO: decodes single-beat accesses
// into push/pop strobes plus a status register and returns one registered response.

package tlul_pkg;
    parameter int TL_AW  = 32;
    parameter int TL_DW  = 32;
    parameter int TL_AIW = 8;
    parameter int TL_DIW = 1;
    parameter int TL_DBW = TL_DW / 8;
    parameter int TL_SZW = 2;
endpackage

module tlul_fifo_bridge
    import tlul_pkg::*;
#(
    parameter int Depth  = 16,
    parameter int LevelW = $clog2(Depth + 1),
    parameter int OffW   = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [2:0]        a_opcode_i,
    input  logic [TL_SZW-1:0] a_size_i,
    input  logic [TL_AIW-1:0] a_source_i,
    input  logic [TL_AW-1:0]  a_address_i,
    input  logic [TL_DBW-1:0] a_mask_i,
    input  logic [TL_DW-1:0]  a_data_i,

    output logic              d_valid_o,
    input  logic              d_ready_i,
    output logic [2:0]        d_opcode_o,
    output logic [TL_SZW-1:0] d_size_o,
    output logic [TL_AIW-1:0] d_source_o,
    output logic [TL_DIW-1:0] d_sink_o,
    output logic [TL_DW-1:0]  d_data_o,
    output logic              d_error_o,

    output logic              push_o,
    output logic [TL_DW-1:0]  wdata_o,
    input  logic              full_i,
    output logic              pop_o,
    input  logic [TL_DW-1:0]  rdata_i,
    input  logic              empty_i,
    input  logic [LevelW-1:0] level_i
);

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] AccessAck     = 3'd0;
    localparam logic [2:0] AccessAckData = 3'd1;
    localparam logic [OffW-1:0] OffData   = OffW'(0);
    localparam logic [OffW-1:0] OffStatus = OffW'(4);

    logic              acc;
    logic              is_get, is_put;
    logic [OffW-1:0]   off;
    logic              err;
    logic              want_push, want_pop;
    logic [TL_DW-1:0]  rsel;
    logic [TL_DW-1:0]  status;
    logic              unused_addr;

    logic              d_valid_q;
    logic [2:0]        d_opcode_q;
    logic [TL_SZW-1:0] d_size_q;
    logic [TL_AIW-1:0] d_source_q;
    logic [TL_DW-1:0]  d_data_q;
    logic              d_error_q;

    assign unused_addr = ^a_address_i[TL_AW-1:OffW];

    assign a_ready_o = !d_valid_q || d_ready_i;
    assign acc       = a_valid_i && a_ready_o;

    assign is_get = (a_opcode_i == OpGet);
    assign is_put = (a_opcode_i == OpPutFull) || (a_opcode_i == OpPutPartial);
    assign off    = a_address_i[OffW-1:0];

    always_comb begin
        status                = '0;
        status[8 +: LevelW]   = level_i;
        status[1]             = full_i;
        status[0]             = empty_i;
    end

    // Decode assumes an access is happening; acc/rst gate the strobes below.
    always_comb begin
        err       = 1'b0;
        want_push = 1'b0;
        want_pop  = 1'b0;
        rsel      = '0;
        if (a_address_i[1:0] != 2'b00 || a_size_i != TL_SZW'(2) || !(is_get || is_put)) begin
            err = 1'b1;
        end else begin
            case (off)
                OffData: begin
                    if (is_get) begin
                        if (empty_i) err = 1'b1;
                        else begin
                            want_pop = 1'b1;
                            rsel     = rdata_i;
                        end
                    end else if (a_mask_i != '1 || full_i) begin
                        err = 1'b1;
                    end else begin
                        want_push = 1'b1;
                    end
                end
                OffStatus: begin
                    if (is_get) rsel = status;
                    else        err  = 1'b1;
                end
                default: err = 1'b1;
            endcase
        end
    end

    assign push_o  = acc && want_push && !rst_i;
    assign pop_o   = acc && want_pop && !rst_i;
    assign wdata_o = a_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
        end else if (acc) begin
            d_valid_q  <= 1'b1;
            d_opcode_q <= is_get ? AccessAckData : AccessAck;
            d_size_q   <= a_size_i;
            d_source_q <= a_source_i;
            d_data_q   <= (err || !is_get) ? '0 : rsel;
            d_error_q  <= err;
        end else if (d_valid_q && d_ready_i) begin
            d_valid_q  <= 1'b0;
        end
    end

    assign d_valid_o  = d_valid_q;
    assign d_opcode_o = d_opcode_q;
    assign d_size_o   = d_size_q;
    assign d_source_o = d_source_q;
    assign d_data_o   = d_data_q;
    assign d_error_o  = d_error_q;
    assign d_sink_o   = '0;

endmodule
